// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared state encoding and slice width for the serial adder
package serial_add_ctrl_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_add2_slice.sv
// rtl/serial_add_ctrl_add2_slice.sv - combinational 2-bit full-adder slice
module add2_slice
    import serial_add_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c,
    output logic [SLICE_W-1:0] sum,
    output logic               carry
);

    logic [SLICE_W:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, c};
    end

    assign sum   = total[SLICE_W-1:0];
    assign carry = total[SLICE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - start/done sequencer stepping one 2-bit adder slice per clock
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_width_check
            $error("serial_add_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
    logic               slice_carry;
    logic               accept;

    assign accept  = start && (state_q == IDLE || state_q == DONE);
    assign slice_a = a_q[SLICE_W*idx_q +: SLICE_W];
    assign slice_b = b_q[SLICE_W*idx_q +: SLICE_W];

    add2_slice u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c     (carry_q),
        .sum   (slice_sum),
        .carry (slice_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == IDX_LAST) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Published sum/cout live apart from the partial result so they only move on the final edge.
    always_comb begin
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
        end else if (state_q == RUN) begin
            result_d[SLICE_W*idx_q +: SLICE_W] = slice_sum;
            carry_d = slice_carry;
            if (idx_q == IDX_LAST) begin
                sum_d  = result_d;
                cout_d = slice_carry;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int tests_run;
    int tests_failed;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and observe 12 cycles after the accepting edge; k=0 is just after E0.
    task automatic do_op(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                         input int inj_k,
                         output int lat, output int busy_cnt, output int done_cnt,
                         output int overlap, output logic [7:0] s, output logic c,
                         output logic [7:0] pre_s);
        @(negedge clk);
        a = ai; b = bi; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_cnt = 0; done_cnt = 0; overlap = 0;
        s = 8'h00; c = 1'b0; pre_s = sum;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k == inj_k) begin
                start = 1'b1; a = ~ai; b = 8'hF0; cin = 1'b1;
            end else if (k == inj_k + 1) begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (busy && done) overlap++;
            if (done) begin
                if (done_cnt == 0) begin
                    lat = k; s = sum; c = cout;
                end
                done_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        int dcnt;
        rst_n = 1'b0; start = 1'b1;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done); end
        tests_run++;
        if (sum !== 8'h00) begin tests_failed++; $display("FAIL reset_sum got=%h exp=00", sum); end
        tests_run++;
        if (cout !== 1'b0) begin tests_failed++; $display("FAIL reset_cout got=%b exp=0", cout); end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        tests_run++;
        if (dcnt !== 0) begin tests_failed++; $display("FAIL reset_idle_activity got=%0d exp=0", dcnt); end
    endtask

    task automatic test_full_ripple();
        int lat, bc, dc, ov;
        logic [7:0] s, ps;
        logic c;
        do_op(8'hFF, 8'h01, 1'b0, -1, lat, bc, dc, ov, s, c, ps);
        tests_run++;
        if (lat !== 4) begin tests_failed++; $display("FAIL ripple_latency got=%0d exp=4", lat); end
        tests_run++;
        if (bc !== 4) begin tests_failed++; $display("FAIL ripple_busy_cycles got=%0d exp=4", bc); end
        tests_run++;
        if (dc !== 1) begin tests_failed++; $display("FAIL ripple_done_count got=%0d exp=1", dc); end
        tests_run++;
        if (ov !== 0) begin tests_failed++; $display("FAIL ripple_busy_done_overlap got=%0d exp=0", ov); end
        tests_run++;
        if (ps !== 8'h00) begin tests_failed++; $display("FAIL ripple_sum_held got=%h exp=00", ps); end
        tests_run++;
        if (s !== 8'h00) begin tests_failed++; $display("FAIL ripple_sum got=%h exp=00", s); end
        tests_run++;
        if (c !== 1'b1) begin tests_failed++; $display("FAIL ripple_cout got=%b exp=1", c); end
    endtask

    task automatic test_carry_in();
        int lat, bc, dc, ov;
        logic [7:0] s, ps;
        logic c;
        do_op(8'h00, 8'h00, 1'b1, -1, lat, bc, dc, ov, s, c, ps);
        tests_run++;
        if (s !== 8'h01) begin tests_failed++; $display("FAIL cin_zero_sum got=%h exp=01", s); end
        tests_run++;
        if (c !== 1'b0) begin tests_failed++; $display("FAIL cin_zero_cout got=%b exp=0", c); end
        do_op(8'hAA, 8'h55, 1'b1, -1, lat, bc, dc, ov, s, c, ps);
        tests_run++;
        if (ps !== 8'h01) begin tests_failed++; $display("FAIL cin_alt_sum_held got=%h exp=01", ps); end
        tests_run++;
        if (s !== 8'h00) begin tests_failed++; $display("FAIL cin_alt_sum got=%h exp=00", s); end
        tests_run++;
        if (c !== 1'b1) begin tests_failed++; $display("FAIL cin_alt_cout got=%b exp=1", c); end
    endtask

    task automatic test_ignored_start();
        int lat, bc, dc, ov;
        logic [7:0] s, ps;
        logic c;
        do_op(8'h0F, 8'h01, 1'b0, 1, lat, bc, dc, ov, s, c, ps);
        tests_run++;
        if (dc !== 1) begin tests_failed++; $display("FAIL ignored_done_count got=%0d exp=1", dc); end
        tests_run++;
        if (lat !== 4) begin tests_failed++; $display("FAIL ignored_latency got=%0d exp=4", lat); end
        tests_run++;
        if (s !== 8'h10) begin tests_failed++; $display("FAIL ignored_sum got=%h exp=10", s); end
        tests_run++;
        if (c !== 1'b0) begin tests_failed++; $display("FAIL ignored_cout got=%b exp=0", c); end
    endtask

    task automatic test_back_to_back();
        int dcnt;
        int dk[3];
        logic [7:0] ds[3];
        logic dc[3];
        logic [7:0] exp_s[3];
        logic exp_c[3];
        int exp_k[3];
        exp_s = '{8'h6D, 8'h00, 8'h80};
        exp_c = '{1'b0, 1'b1, 1'b0};
        exp_k = '{4, 9, 14};
        dcnt = 0;
        for (int i = 0; i < 3; i++) begin
            dk[i] = -1; ds[i] = 8'h00; dc[i] = 1'b0;
        end
        @(negedge clk);
        a = 8'h3A; b = 8'h32; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        a = 8'h80; b = 8'h80; cin = 1'b0;
        for (int k = 1; k < 22; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin a = 8'h7F; b = 8'h01; cin = 1'b0; end
            if (k == 10) start = 1'b0;
            if (done) begin
                if (dcnt < 3) begin
                    dk[dcnt] = k; ds[dcnt] = sum; dc[dcnt] = cout;
                end
                dcnt++;
            end
        end
        tests_run++;
        if (dcnt !== 3) begin tests_failed++; $display("FAIL b2b_done_count got=%0d exp=3", dcnt); end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (dk[i] !== exp_k[i]) begin
                tests_failed++; $display("FAIL b2b_done_cycle[%0d] got=%0d exp=%0d", i, dk[i], exp_k[i]);
            end
            tests_run++;
            if (ds[i] !== exp_s[i]) begin
                tests_failed++; $display("FAIL b2b_sum[%0d] got=%h exp=%h", i, ds[i], exp_s[i]);
            end
            tests_run++;
            if (dc[i] !== exp_c[i]) begin
                tests_failed++; $display("FAIL b2b_cout[%0d] got=%b exp=%b", i, dc[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc, dc, ov, dcnt;
        logic [7:0] s, ps;
        logic c;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        tests_run++;
        if (sum !== 8'h00) begin tests_failed++; $display("FAIL midrst_sum got=%h exp=00", sum); end
        tests_run++;
        if (cout !== 1'b0) begin tests_failed++; $display("FAIL midrst_cout got=%b exp=0", cout); end
        dcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        tests_run++;
        if (dcnt !== 0) begin tests_failed++; $display("FAIL midrst_no_done got=%0d exp=0", dcnt); end
        do_op(8'h12, 8'h34, 1'b0, -1, lat, bc, dc, ov, s, c, ps);
        tests_run++;
        if (s !== 8'h46) begin tests_failed++; $display("FAIL midrst_next_sum got=%h exp=46", s); end
        tests_run++;
        if (c !== 1'b0) begin tests_failed++; $display("FAIL midrst_next_cout got=%b exp=0", c); end
        tests_run++;
        if (lat !== 4) begin tests_failed++; $display("FAIL midrst_next_latency got=%0d exp=4", lat); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        test_reset();
        test_full_ripple();
        test_carry_in();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
